// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and data-memory port B.
// Sub-word RAM stores use read-modify-write. Sub-word MMIO stores skip the read
// so that a store never triggers a side-effecting MMIO read.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for Req; the request is latched on accept
// ST_ACCESS| port-B read: load data, or the RMW word, captured at exit
// ST_WRITE | MemWriteEn high for this single cycle
// ST_DONE  | Done pulse, Fault valid; always returns to ST_IDLE
module mem_access_unit #(
    parameter logic [15:0] MMIO_PREFIX = 16'hffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    input  logic [31:0] MemReadData,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEn,
    output logic [31:0] LoadData,
    output logic        Done,
    output logic        Fault,
    output logic        Busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WRITE, ST_DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, load_q;
    logic [2:0]  funct3_q;
    logic        store_q, fault_q;

    logic        accept, active, illegal, misaligned, req_fault, is_mmio, sub_word;
    logic [31:0] lane_word, extended, merged;

    // Request decode, evaluated on the live inputs while in IDLE.
    always_comb begin
        accept     = (state == ST_IDLE) && Req;
        active     = MemRead || MemWrite;
        illegal    = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
        misaligned = ((Funct3[1:0] == 2'b01) && Address[0]) ||
                     ((Funct3[1:0] == 2'b10) && (Address[1:0] != 2'b00));
        req_fault  = active && (illegal || misaligned);
        is_mmio    = (Address[31:16] == MMIO_PREFIX);
        sub_word   = (Funct3[1:0] != 2'b10);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a no-op request (neither read nor write) just pulses Done.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Req) begin
                    if (!active || req_fault) begin
                        state_nxt = ST_DONE;
                    end else if (MemWrite && (!sub_word || is_mmio)) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: state_nxt = store_q ? ST_WRITE : ST_DONE;
            ST_WRITE:  state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Load extension and RMW lane merge, both working on the word read in ACCESS.
    always_comb begin
        lane_word = MemReadData >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  extended = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  extended = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  extended = {24'b0, lane_word[7:0]};
            3'b101:  extended = {16'b0, lane_word[15:0]};
            default: extended = MemReadData;
        endcase

        merged = MemReadData;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Request latch and datapath registers. wdata_q first holds the zero-extended
    // store operand (used as-is for SW and MMIO) and is overwritten with the
    // merged word when an RMW read completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            fault_q  <= 1'b0;
            wdata_q  <= '0;
            load_q   <= '0;
        end else begin
            if (accept) begin
                addr_q   <= Address;
                funct3_q <= Funct3;
                store_q  <= MemWrite;
                fault_q  <= req_fault;
                if (!sub_word) begin
                    wdata_q <= StoreData;
                end else if (Funct3[1:0] == 2'b00) begin
                    wdata_q <= {24'b0, StoreData[7:0]};
                end else begin
                    wdata_q <= {16'b0, StoreData[15:0]};
                end
                if (req_fault) begin
                    load_q <= '0;
                end
            end
            if (state == ST_ACCESS) begin
                if (store_q) begin
                    wdata_q <= merged;
                end else begin
                    load_q <= extended;
                end
            end
        end
    end

    assign MemAddress   = addr_q;
    assign LoadData     = load_q;
    assign MemWriteEn   = (state == ST_WRITE);
    assign MemWriteData = (state == ST_WRITE) ? wdata_q : '0;
    assign Done         = (state == ST_DONE);
    assign Fault        = (state == ST_DONE) && fault_q;
    assign Busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// requests checked against a behavioural load/store model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Address, StoreData, MemReadData;
    logic [31:0] MemAddress, MemWriteData, LoadData;
    logic        MemWriteEn, Done, Fault, Busy;

    int          checks = 0;
    int          failures = 0;
    int          wr_total = 0;
    logic [31:0] exp_load = '0;
    logic [31:0] ram  [256];
    logic [31:0] mmio [256];

    always #5 clk = ~clk;

    assign MemReadData = (MemAddress[31:16] == 16'hffff) ? mmio[MemAddress[9:2]]
                                                         : ram[MemAddress[9:2]];

    mem_access_unit #(.MMIO_PREFIX(16'hffff)) dut (
        .clk(clk), .reset(reset), .Req(Req), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .Address(Address), .StoreData(StoreData),
        .MemReadData(MemReadData), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWriteEn(MemWriteEn), .LoadData(LoadData), .Done(Done), .Fault(Fault),
        .Busy(Busy)
    );

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        return (a[31:16] == 16'hffff) ? mmio[a[9:2]] : ram[a[9:2]];
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
        if (a[31:16] == 16'hffff) mmio[a[9:2]] = d;
        else                      ram[a[9:2]]  = d;
        wr_total++;
    endtask

    // Issue one request in IDLE and follow it to Done (bounded); port-B writes
    // observed on the way are applied to the memory model.
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          output int lat, output logic flt, output int we_cyc,
                          output logic [31:0] wd, output logic leak);
        @(negedge clk);
        Req = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; Address = a; StoreData = sd;
        @(posedge clk);
        #1 Req = 1'b0;
        lat = -1; flt = 1'b0; we_cyc = -1; wd = '0; leak = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!MemWriteEn && MemWriteData !== 32'h0) leak = 1'b1;
            if (MemWriteEn) begin
                if (we_cyc < 0) begin
                    we_cyc = c;
                    wd = MemWriteData;
                end
                mem_write(MemAddress, MemWriteData);
            end
            if (Done) begin
                lat = c;
                flt = Fault;
                break;
            end
        end
    endtask

    // Reference model: expected cycles to Done, fault, write count and new word.
    task automatic ref_model(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             output int lat, output logic flt, output int nwr,
                             output logic [31:0] new_word);
        logic [31:0] old, v, b, mask;
        int          size, shift;
        logic        bad;
        old   = mem_peek(a);
        size  = int'(f3[1:0]);
        shift = 8 * int'(a % 4);
        bad   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
                (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
        new_word = old;
        nwr = 0;
        flt = 1'b0;
        if (!rd && !wr) begin
            lat = 1;
        end else if (bad) begin
            lat = 1;
            flt = 1'b1;
            exp_load = '0;
        end else if (wr) begin
            nwr = 1;
            if (size == 2) begin
                lat = 2;
                new_word = sd;
            end else if (a[31:16] == 16'hffff) begin
                lat = 2;
                new_word = (size == 0) ? (sd & 32'hFF) : (sd & 32'hFFFF);
            end else begin
                lat = 3;
                mask = ((size == 0) ? 32'hFF : 32'hFFFF) << shift;
                new_word = (old & ~mask) | ((sd << shift) & mask);
            end
        end else begin
            lat = 2;
            v = old >> shift;
            case (f3)
                3'd0: begin b = v & 32'hFF;   if (b >= 32'd128)   b = b - 32'd256;   exp_load = b; end
                3'd1: begin b = v & 32'hFFFF; if (b >= 32'd32768) b = b - 32'd65536; exp_load = b; end
                3'd4: exp_load = v & 32'hFF;
                3'd5: exp_load = v & 32'hFFFF;
                default: exp_load = old;
            endcase
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({MemWriteEn, MemWriteData, MemAddress, LoadData, Done, Fault, Busy} !== 99'b0) begin
            failures++;
            $display("FAIL reset_held outputs=%h exp=0",
                     {MemWriteEn, MemWriteData, MemAddress, LoadData, Done, Fault, Busy});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({MemWriteEn, MemWriteData, MemAddress, LoadData, Done, Fault, Busy} !== 99'b0) begin
            failures++;
            $display("FAIL reset_release outputs=%h exp=0",
                     {MemWriteEn, MemWriteData, MemAddress, LoadData, Done, Fault, Busy});
        end
    endtask

    task automatic test_load();
        int lat, wc; logic flt, lk; logic [31:0] wd;
        ram[32'h40] = 32'h8034_12F0;
        do_req(1, 0, 3'b000, 32'h103, 32'h0, lat, flt, wc, wd, lk);
        checks++; if (lat !== 2)                   begin failures++; $display("FAIL lb_latency got=%0d exp=2", lat); end
        checks++; if (LoadData !== 32'hFFFF_FF80)  begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", LoadData); end
        checks++; if (flt !== 1'b0 || wc != -1)     begin failures++; $display("FAIL lb_flags fault=%b wecyc=%0d exp 0/-1", flt, wc); end
        do_req(1, 0, 3'b100, 32'h103, 32'h0, lat, flt, wc, wd, lk);
        checks++; if (LoadData !== 32'h0000_0080)  begin failures++; $display("FAIL lbu_data got=%h exp=00000080", LoadData); end
        do_req(1, 0, 3'b001, 32'h102, 32'h0, lat, flt, wc, wd, lk);
        checks++; if (LoadData !== 32'hFFFF_8034)  begin failures++; $display("FAIL lh_data got=%h exp=ffff8034", LoadData); end
        do_req(1, 0, 3'b101, 32'h100, 32'h0, lat, flt, wc, wd, lk);
        checks++; if (LoadData !== 32'h0000_12F0)  begin failures++; $display("FAIL lhu_data got=%h exp=000012f0", LoadData); end
        do_req(1, 0, 3'b010, 32'h100, 32'h0, lat, flt, wc, wd, lk);
        checks++; if (LoadData !== 32'h8034_12F0)  begin failures++; $display("FAIL lw_data got=%h exp=803412f0", LoadData); end
    endtask

    task automatic test_sub_store();
        int lat, wc, w0; logic flt, lk; logic [31:0] wd;
        ram[32'h40] = 32'h1122_3344;
        w0 = wr_total;
        do_req(0, 1, 3'b000, 32'h101, 32'h0000_00AB, lat, flt, wc, wd, lk);
        checks++; if (lat !== 3)                   begin failures++; $display("FAIL sb_latency got=%0d exp=3", lat); end
        checks++; if (wr_total - w0 != 1)          begin failures++; $display("FAIL sb_write_count got=%0d exp=1", wr_total - w0); end
        checks++; if (ram[32'h40] !== 32'h1122_AB44) begin failures++; $display("FAIL sb_word got=%h exp=1122ab44", ram[32'h40]); end
        checks++; if (wc !== 2)                    begin failures++; $display("FAIL sb_write_cycle got=%0d exp=2", wc); end
        do_req(0, 1, 3'b001, 32'h102, 32'h1234_5678, lat, flt, wc, wd, lk);
        checks++; if (ram[32'h40] !== 32'h5678_AB44) begin failures++; $display("FAIL sh_word got=%h exp=5678ab44", ram[32'h40]); end
    endtask

    task automatic test_fault();
        int lat, wc, w0; logic flt, lk; logic [31:0] wd;
        w0 = wr_total;
        do_req(1, 0, 3'b010, 32'h102, 32'h0, lat, flt, wc, wd, lk);
        checks++; if (lat !== 1 || flt !== 1'b1)   begin failures++; $display("FAIL lw_misalign lat=%0d fault=%b exp 1/1", lat, flt); end
        checks++; if (LoadData !== 32'h0)          begin failures++; $display("FAIL lw_misalign_data got=%h exp=0", LoadData); end
        do_req(1, 0, 3'b100, 32'h103, 32'h0, lat, flt, wc, wd, lk);
        do_req(1, 0, 3'b011, 32'h100, 32'h0, lat, flt, wc, wd, lk);
        checks++; if (lat !== 1 || flt !== 1'b1)   begin failures++; $display("FAIL f3_illegal lat=%0d fault=%b exp 1/1", lat, flt); end
        checks++; if (LoadData !== 32'h0)          begin failures++; $display("FAIL f3_illegal_data got=%h exp=0", LoadData); end
        do_req(0, 1, 3'b001, 32'h101, 32'hFFFF, lat, flt, wc, wd, lk);
        checks++; if (lat !== 1 || flt !== 1'b1)   begin failures++; $display("FAIL sh_misalign lat=%0d fault=%b exp 1/1", lat, flt); end
        checks++; if (wr_total != w0 || wc != -1)  begin failures++; $display("FAIL fault_no_write writes=%0d exp=0", wr_total - w0); end
        do_req(0, 0, 3'b010, 32'h100, 32'h0, lat, flt, wc, wd, lk);
        checks++; if (lat !== 1 || flt !== 1'b0)   begin failures++; $display("FAIL noop lat=%0d fault=%b exp 1/0", lat, flt); end
    endtask

    task automatic test_mmio();
        int lat, wc; logic flt, lk; logic [31:0] wd;
        mmio[4] = 32'hA5A5_A5A5;
        do_req(0, 1, 3'b001, 32'hFFFF_0010, 32'h0000_BEEF, lat, flt, wc, wd, lk);
        checks++; if (wc !== 1 || lat !== 2)       begin failures++; $display("FAIL mmio_sh_timing wecyc=%0d lat=%0d exp 1/2", wc, lat); end
        checks++; if (wd !== 32'h0000_BEEF)        begin failures++; $display("FAIL mmio_sh_data got=%h exp=0000beef", wd); end
        do_req(0, 1, 3'b000, 32'hFFFF_0013, 32'h1234_56C3, lat, flt, wc, wd, lk);
        checks++; if (wd !== 32'h0000_00C3 || wc !== 1) begin failures++; $display("FAIL mmio_sb_data got=%h wecyc=%0d exp=000000c3/1", wd, wc); end
    endtask

    task automatic test_reset_rmw();
        int w0;
        ram[32'h80] = 32'hDEAD_BEEF;
        w0 = wr_total;
        @(negedge clk);
        Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b000;
        Address = 32'h201; StoreData = 32'h55;
        @(posedge clk);
        #1 Req = 1'b0;
        @(negedge clk);
        checks++; if (Busy !== 1'b1 || MemWriteEn !== 1'b0) begin failures++; $display("FAIL rmw_access busy=%b we=%b exp 1/0", Busy, MemWriteEn); end
        reset = 1'b0;
        #1;
        checks++;
        if ({MemWriteEn, MemWriteData, MemAddress, LoadData, Done, Fault, Busy} !== 99'b0) begin
            failures++;
            $display("FAIL rmw_async_reset outputs=%h exp=0",
                     {MemWriteEn, MemWriteData, MemAddress, LoadData, Done, Fault, Busy});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (MemWriteEn) mem_write(MemAddress, MemWriteData);
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (MemWriteEn) mem_write(MemAddress, MemWriteData);
        end
        exp_load = '0;
        checks++; if (ram[32'h80] !== 32'hDEAD_BEEF || wr_total != w0) begin failures++; $display("FAIL rmw_abandon word=%h writes=%0d exp=deadbeef/0", ram[32'h80], wr_total - w0); end
        checks++;
        if ({MemWriteEn, MemWriteData, MemAddress, LoadData, Done, Fault, Busy} !== 99'b0) begin
            failures++;
            $display("FAIL rmw_after_release outputs=%h exp=0",
                     {MemWriteEn, MemWriteData, MemAddress, LoadData, Done, Fault, Busy});
        end
    endtask

    task automatic test_back_to_back();
        int w0, dones, lat, wc; logic flt, lk; logic [31:0] wd;
        w0 = wr_total;
        dones = 0;
        @(negedge clk);
        Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010;
        Address = 32'h180; StoreData = 32'hCAFE_F00D;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (MemWriteEn) mem_write(MemAddress, MemWriteData);
            if (Done) dones++;
            if (c == 1) begin
                Address = 32'h184;
                StoreData = 32'h0BAD_BEEF;
            end
            if (c == 3) Req = 1'b0;
        end
        checks++; if (dones != 1)                  begin failures++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
        checks++; if (wr_total - w0 != 1)          begin failures++; $display("FAIL busy_write_count got=%0d exp=1", wr_total - w0); end
        checks++; if (ram[32'h60] !== 32'hCAFE_F00D) begin failures++; $display("FAIL busy_word got=%h exp=cafef00d", ram[32'h60]); end
        do_req(0, 1, 3'b010, 32'h188, 32'h1357_9BDF, lat, flt, wc, wd, lk);
        checks++; if (lat !== 2 || ram[32'h62] !== 32'h1357_9BDF) begin failures++; $display("FAIL after_busy lat=%0d word=%h exp 2/13579bdf", lat, ram[32'h62]); end
    endtask

    task automatic test_random();
        int lat, wc, w0, kind, e_lat, e_nwr, e_wc;
        logic flt, lk, e_flt, rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, sd, wd, e_word;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            rd = (kind >= 1 && kind <= 4);
            wr = (kind >= 5);
            case ($urandom_range(0, 9))
                0:       f3 = 3'd3 + 3'($urandom_range(0, 1)) * 3'd3;
                1:       f3 = 3'd7;
                default: f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            endcase
            if (f3 == 3'd3 && !rd && !wr) f3 = 3'd2;
            if (f3 >= 3'd6 && !rd && !wr) f3 = 3'd0;
            if (!wr && f3 == 3'd3 && $urandom_range(0, 1) == 0) f3 = 3'd4;
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) a = a | 32'hFFFF_0000;
            sd = $urandom;
            w0 = wr_total;
            ref_model(rd, wr, f3, a, sd, e_lat, e_flt, e_nwr, e_word);
            e_wc = (e_nwr != 0) ? e_lat - 1 : -1;
            do_req(rd, wr, f3, a, sd, lat, flt, wc, wd, lk);
            checks++; if (lat !== e_lat)           begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, e_lat); end
            checks++; if (flt !== e_flt)           begin failures++; $display("FAIL rnd%0d_fault got=%b exp=%b", i, flt, e_flt); end
            checks++; if (LoadData !== exp_load)   begin failures++; $display("FAIL rnd%0d_loaddata got=%h exp=%h", i, LoadData, exp_load); end
            checks++; if (wr_total - w0 != e_nwr)  begin failures++; $display("FAIL rnd%0d_writes got=%0d exp=%0d", i, wr_total - w0, e_nwr); end
            checks++; if (mem_peek(a) !== e_word)  begin failures++; $display("FAIL rnd%0d_word got=%h exp=%h", i, mem_peek(a), e_word); end
            checks++; if (wc !== e_wc)             begin failures++; $display("FAIL rnd%0d_write_cycle got=%0d exp=%0d", i, wc, e_wc); end
            checks++; if (lk !== 1'b0)             begin failures++; $display("FAIL rnd%0d_wdata_idle got=%b exp=0", i, lk); end
            checks++; if (MemAddress !== a)        begin failures++; $display("FAIL rnd%0d_memaddress got=%h exp=%h", i, MemAddress, a); end
        end
    endtask

    initial begin
        reset = 1'b0;
        Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
        Address = '0; StoreData = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i]  = $urandom;
            mmio[i] = $urandom;
        end
        test_reset();
        test_load();
        test_sub_store();
        test_fault();
        test_mmio();
        test_reset_rmw();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
